// File: rtl/tx_fc_update_coalescer_pkg.sv
`default_nettype none
// ============================================================================
// Package : Tx_Arbiter_Package
// Brief   : Shared flow-control type encoding and helpers for the Tx arbiter
//           and the UpdateFC coalescer.
// Rev     : 1.0 - initial release
// ============================================================================
package Tx_Arbiter_Package;

  // Flow-control type encoding; FC_X marks "no type / nothing presented".
  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2,
    FC_X   = 2'd3
  } fc_type_e;

  localparam int NUM_FC_TYPES = 3;

  // Converts a one-hot grant (bit0 P, bit1 NP, bit2 CPL) to its type code.
  function automatic fc_type_e onehot_to_type(input logic [NUM_FC_TYPES-1:0] oh);
    fc_type_e t;
    case (oh)
      3'b001:  t = FC_P;
      3'b010:  t = FC_NP;
      3'b100:  t = FC_CPL;
      default: t = FC_X;
    endcase
    return t;
  endfunction

endpackage : Tx_Arbiter_Package
`default_nettype wire

// File: rtl/tx_fc_update_coalescer_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : tx_fc_rr_picker
// Brief  : 3-way round-robin selector. Search starts at the type following
//          the last granted one; grant is one-hot, valid when any request set.
// Rev    : 1.0 - initial release
// ============================================================================
module tx_fc_rr_picker
  import Tx_Arbiter_Package::*;
(
  input  logic [NUM_FC_TYPES-1:0] i_req,
  input  fc_type_e                i_last_grant,
  output logic [NUM_FC_TYPES-1:0] o_grant,
  output logic                    o_valid
);

  // Rotating priority: the most recently served type has lowest priority.
  always_comb begin
    o_grant = '0;
    case (i_last_grant)
      FC_P: begin
        if      (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
      end
      FC_NP: begin
        if      (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
      end
      // CPL (and the never-expected FC_X) start the search at P.
      default: begin
        if      (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
      end
    endcase
  end

  assign o_valid = |i_req;

endmodule : tx_fc_rr_picker
`default_nettype wire

// File: rtl/tx_fc_update_coalescer.sv
`default_nettype none
// ============================================================================
// Module : tx_fc_update_coalescer
// Brief  : Coalesces UpdateFC/InitFC DLLPs into one slot per FC type
//          (newest absolute limit wins) and presents them one at a time to
//          Tx_FC via a held output register with round-robin type selection.
// Config : TX_FC_UPDATE_WATCHDOG_EN - per-type update timeout counters.
// Rev    : 1.0 - initial release
// ============================================================================
module tx_fc_update_coalescer
  import Tx_Arbiter_Package::*;
#(
  parameter int FC_HDR_WIDTH  = 12,
  parameter int FC_DATA_WIDTH = 16,
  parameter int WDT_CYCLES    = 1024
)
(
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     dll_fc_valid,
  input  logic [1:0]               dll_fc_type,
  input  logic [FC_HDR_WIDTH-1:0]  dll_fc_hdr,
  input  logic [FC_DATA_WIDTH-1:0] dll_fc_data,
  input  logic                     fc_ready,
  output logic [1:0]               TypeFC,
  output logic [FC_HDR_WIDTH-1:0]  HdrFC,
  output logic [FC_DATA_WIDTH-1:0] DataFC,
  output logic [2:0]               fc_pending,
  output logic                     fc_init_done,
  output logic [2:0]               fc_timeout
);

  logic [NUM_FC_TYPES-1:0]  w_wr_onehot;
  logic [NUM_FC_TYPES-1:0]  w_slot_vld;
  logic [FC_HDR_WIDTH-1:0]  w_slot_hdr  [NUM_FC_TYPES];
  logic [FC_DATA_WIDTH-1:0] w_slot_data [NUM_FC_TYPES];
  logic [NUM_FC_TYPES-1:0]  w_grant;
  logic                     w_pick_vld;
  logic                     w_load;
  logic                     w_take;
  fc_type_e                 w_sel_type;
  logic [FC_HDR_WIDTH-1:0]  w_sel_hdr;
  logic [FC_DATA_WIDTH-1:0] w_sel_data;

  fc_type_e                 r_type;
  logic [FC_HDR_WIDTH-1:0]  r_hdr;
  logic [FC_DATA_WIDTH-1:0] r_data;
  fc_type_e                 r_last;
  logic [NUM_FC_TYPES-1:0]  r_seen;

  // FC_X strobes decode to no slot at all.
  assign w_wr_onehot = (dll_fc_valid && (dll_fc_type != FC_X))
                       ? (3'b001 << dll_fc_type) : 3'b000;

  // Output register is free when empty or when Tx_FC takes the current value.
  assign w_load = (r_type == FC_X) || fc_ready;
  assign w_take = w_load && w_pick_vld;

  // One slot per type; a write always wins over the clear from a load so a
  // same-cycle update stays pending with its new value.
  for (genvar i = 0; i < NUM_FC_TYPES; i++) begin : g_slot
    logic                     r_vld;
    logic [FC_HDR_WIDTH-1:0]  r_shdr;
    logic [FC_DATA_WIDTH-1:0] r_sdata;

    // Slot capture and consume.
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        r_vld   <= 1'b0;
        r_shdr  <= '0;
        r_sdata <= '0;
      end else if (w_wr_onehot[i]) begin
        r_vld   <= 1'b1;
        r_shdr  <= dll_fc_hdr;
        r_sdata <= dll_fc_data;
      end else if (w_take && w_grant[i]) begin
        r_vld   <= 1'b0;
      end
    end

    assign w_slot_vld[i]  = r_vld;
    assign w_slot_hdr[i]  = r_shdr;
    assign w_slot_data[i] = r_sdata;
  end

  tx_fc_rr_picker u_picker (
    .i_req        (w_slot_vld),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_valid      (w_pick_vld)
  );

  assign w_sel_type = onehot_to_type(w_grant);

  // One-hot mux of the granted slot's limits.
  always_comb begin
    w_sel_hdr  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_FC_TYPES; i++) begin
      if (w_grant[i]) begin
        w_sel_hdr  = w_sel_hdr  | w_slot_hdr[i];
        w_sel_data = w_sel_data | w_slot_data[i];
      end
    end
  end

  // Presented update: loads the next slot or empties; the round-robin
  // pointer only moves when a slot is actually selected.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_type <= FC_X;
      r_hdr  <= '0;
      r_data <= '0;
      r_last <= FC_CPL;
    end else if (w_load) begin
      if (w_pick_vld) begin
        r_type <= w_sel_type;
        r_hdr  <= w_sel_hdr;
        r_data <= w_sel_data;
        r_last <= w_sel_type;
      end else begin
        r_type <= FC_X;
        r_hdr  <= '0;
        r_data <= '0;
      end
    end
  end

  // Sticky record of which types have been written since reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_seen <= '0;
    end else begin
      r_seen <= r_seen | w_wr_onehot;
    end
  end

  assign TypeFC       = r_type;
  assign HdrFC        = r_hdr;
  assign DataFC       = r_data;
  assign fc_pending   = w_slot_vld;
  assign fc_init_done = &r_seen;

`ifdef TX_FC_UPDATE_WATCHDOG_EN
  localparam int c_wdt_w = $clog2(WDT_CYCLES + 1);
  localparam logic [c_wdt_w-1:0] c_wdt_max = c_wdt_w'(WDT_CYCLES);

  for (genvar i = 0; i < NUM_FC_TYPES; i++) begin : g_wdt
    logic [c_wdt_w-1:0] r_cnt;

    // Cycles since the last write of this type, saturating at the threshold.
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        r_cnt <= '0;
      end else if (w_wr_onehot[i]) begin
        r_cnt <= '0;
      end else if (r_cnt != c_wdt_max) begin
        r_cnt <= r_cnt + c_wdt_w'(1);
      end
    end

    assign fc_timeout[i] = (r_cnt == c_wdt_max) && fc_init_done;
  end
`else
  assign fc_timeout = 3'b000;
`endif

endmodule : tx_fc_update_coalescer
`default_nettype wire

// File: tb/tb_tx_fc_update_coalescer.sv
`default_nettype none
// ============================================================================
// Module : tb_tx_fc_update_coalescer
// Brief  : Directed, table-driven self-checking bench for the UpdateFC
//          coalescer, plus hand-written watchdog and mid-run reset sequences.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tx_fc_update_coalescer;

  localparam int HW = 12;
  localparam int DW = 16;

  logic          clk;
  logic          arst;
  logic          dll_fc_valid;
  logic [1:0]    dll_fc_type;
  logic [HW-1:0] dll_fc_hdr;
  logic [DW-1:0] dll_fc_data;
  logic          fc_ready;
  logic [1:0]    TypeFC;
  logic [HW-1:0] HdrFC;
  logic [DW-1:0] DataFC;
  logic [2:0]    fc_pending;
  logic          fc_init_done;
  logic [2:0]    fc_timeout;

  int checks = 0;
  int errors = 0;

  tx_fc_update_coalescer #(
    .FC_HDR_WIDTH  (HW),
    .FC_DATA_WIDTH (DW),
    .WDT_CYCLES    (16)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .dll_fc_valid (dll_fc_valid),
    .dll_fc_type  (dll_fc_type),
    .dll_fc_hdr   (dll_fc_hdr),
    .dll_fc_data  (dll_fc_data),
    .fc_ready     (fc_ready),
    .TypeFC       (TypeFC),
    .HdrFC        (HdrFC),
    .DataFC       (DataFC),
    .fc_pending   (fc_pending),
    .fc_init_done (fc_init_done),
    .fc_timeout   (fc_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    bit            v;
    logic [1:0]    t;
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    bit            rdy;
    logic [1:0]    et;
    logic [HW-1:0] eh;
    logic [DW-1:0] ed;
    logic [2:0]    ep;
    bit            ei;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit v, input logic [1:0] t, input int h, input int d,
                     input bit rdy, input logic [1:0] et, input int eh, input int ed,
                     input logic [2:0] ep, input bit ei);
    vec_t x;
    x.v = v; x.t = t; x.h = HW'(h); x.d = DW'(d); x.rdy = rdy;
    x.et = et; x.eh = HW'(eh); x.ed = DW'(ed); x.ep = ep; x.ei = ei;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] t, input int h, input int d, input bit rdy);
    dll_fc_valid = v;
    dll_fc_type  = t;
    dll_fc_hdr   = HW'(h);
    dll_fc_data  = DW'(d);
    fc_ready     = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Types: 0 P, 1 NP, 2 CPL, 3 X. Expected values are after the edge.
    //   v  t  hdr  data rdy  et  eh  ed    ep      ei
    // Basic in-order delivery and init_done.
    add(1, 0, 10, 1000, 1,  3,  0,    0, 3'b001, 0);
    add(1, 1, 20, 2000, 1,  0, 10, 1000, 3'b010, 0);
    add(1, 2, 30, 3000, 1,  1, 20, 2000, 3'b100, 1);
    add(0, 0,  0,    0, 1,  2, 30, 3000, 3'b000, 1);
    add(0, 0,  0,    0, 1,  3,  0,    0, 3'b000, 1);
    // FC_X strobe ignored.
    add(1, 3,  5,    5, 1,  3,  0,    0, 3'b000, 1);
    // Held NP output, P overwritten twice, newest presented on ready.
    add(1, 1,  1,   11, 0,  3,  0,    0, 3'b010, 1);
    add(1, 0,  5,   50, 0,  1,  1,   11, 3'b001, 1);
    add(1, 0,  7,   70, 0,  1,  1,   11, 3'b001, 1);
    add(0, 0,  0,    0, 0,  1,  1,   11, 3'b001, 1);
    add(0, 0,  0,    0, 1,  0,  7,   70, 3'b000, 1);
    add(0, 0,  0,    0, 1,  3,  0,    0, 3'b000, 1);
    // All three pending behind a held CPL: grant order P, NP, CPL.
    add(1, 2,  9,   90, 0,  3,  0,    0, 3'b100, 1);
    add(1, 0,  1,    2, 0,  2,  9,   90, 3'b001, 1);
    add(1, 1,  3,    4, 0,  2,  9,   90, 3'b011, 1);
    add(1, 2,  5,    6, 0,  2,  9,   90, 3'b111, 1);
    add(0, 0,  0,    0, 1,  0,  1,    2, 3'b110, 1);
    add(0, 0,  0,    0, 1,  1,  3,    4, 3'b100, 1);
    add(0, 0,  0,    0, 1,  2,  5,    6, 3'b000, 1);
    add(0, 0,  0,    0, 1,  3,  0,    0, 3'b000, 1);
    // Write to the slot being loaded: old value out, new value stays pending.
    add(1, 1,  8,   80, 1,  3,  0,    0, 3'b010, 1);
    add(1, 1,  9,   90, 1,  1,  8,   80, 3'b010, 1);
    add(0, 0,  0,    0, 1,  1,  9,   90, 3'b000, 1);
    add(0, 0,  0,    0, 1,  3,  0,    0, 3'b000, 1);

    arst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    @(negedge clk);
    arst = 1'b0;
    #1;
    check("reset_type",    int'(TypeFC), 3);
    check("reset_hdr",     int'(HdrFC), 0);
    check("reset_data",    int'(DataFC), 0);
    check("reset_pending", int'(fc_pending), 0);
    check("reset_init",    int'(fc_init_done), 0);
    check("reset_timeout", int'(fc_timeout), 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].t, int'(vq[i].h), int'(vq[i].d), vq[i].rdy);
      step();
      check($sformatf("v%0d_type", i),    int'(TypeFC),       int'(vq[i].et));
      check($sformatf("v%0d_hdr", i),     int'(HdrFC),        int'(vq[i].eh));
      check($sformatf("v%0d_data", i),    int'(DataFC),       int'(vq[i].ed));
      check($sformatf("v%0d_pending", i), int'(fc_pending),   int'(vq[i].ep));
      check($sformatf("v%0d_init", i),    int'(fc_init_done), int'(vq[i].ei));
    end

`ifdef TX_FC_UPDATE_WATCHDOG_EN
    // NP written once, then only P/CPL: NP times out after 16 cycles.
    drive(1, 1, 1, 1, 1);
    step();
    for (int k = 1; k <= 15; k++) begin
      drive(1, (k % 2 == 1) ? 2'd0 : 2'd2, k, k, 1);
      step();
    end
    check("wdt_below_threshold", int'(fc_timeout), 0);
    drive(1, 2'd0, 3, 3, 1);
    step();
    check("wdt_np_timeout", int'(fc_timeout), 2);
    drive(1, 2'd1, 4, 4, 1);
    step();
    check("wdt_np_cleared", int'(fc_timeout), 0);
    drive(0, 0, 0, 0, 1);
    repeat (4) step();
`else
    check("timeout_const_zero", int'(fc_timeout), 0);
`endif

    // Mid-run reset with a held NP output and a pending P slot.
    drive(0, 0, 0, 0, 1);
    step();
    drive(1, 1, 100, 1000, 0);
    step();
    drive(1, 0, 200, 2000, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    check("pre_rst_type",    int'(TypeFC), 1);
    check("pre_rst_hdr",     int'(HdrFC), 100);
    check("pre_rst_pending", int'(fc_pending), 1);
    #2;
    arst = 1'b1;
    #1;
    check("async_rst_type",    int'(TypeFC), 3);
    check("async_rst_hdr",     int'(HdrFC), 0);
    check("async_rst_data",    int'(DataFC), 0);
    check("async_rst_pending", int'(fc_pending), 0);
    check("async_rst_init",    int'(fc_init_done), 0);
    check("async_rst_timeout", int'(fc_timeout), 0);
    @(negedge clk);
    arst = 1'b0;
    drive(0, 0, 0, 0, 1);
    step();
    check("post_rst_type",    int'(TypeFC), 3);
    check("post_rst_pending", int'(fc_pending), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tx_fc_update_coalescer
`default_nettype wire
